// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle between NREQ clients and the shared gate unit.
// Carries resp_parity only when GATE_ARB_PARITY_EN is defined.
interface gate_op_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_y;
`ifdef GATE_ARB_PARITY_EN
  logic                  resp_parity;
`endif

  // Client side: requesters plus the response consumer.
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y
`ifdef GATE_ARB_PARITY_EN
    , input resp_parity
`endif
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y
`ifdef GATE_ARB_PARITY_EN
    , output resp_parity
`endif
  );
endinterface

// File: rtl/gate_op_arbiter.sv
// Round-robin shared AND/OR/XOR/XNOR gate unit: IDLE (grant) -> EXEC -> RESP.
// Optional resp_parity output enabled by defining GATE_ARB_PARITY_EN.
module gate_op_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_op_arbiter_if.slave    bus,
  output logic                busy
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDW-1:0]   r_resp_id;
  logic [WIDTH-1:0] r_resp_y;
`ifdef GATE_ARB_PARITY_EN
  logic             r_resp_parity;
`endif

  logic [1:0]       w_op   [NREQ];
  logic [WIDTH-1:0] w_a    [NREQ];
  logic [WIDTH-1:0] w_b    [NREQ];
  logic [IDW-1:0]   w_cand [NREQ];
  logic             w_any;
  logic [IDW-1:0]   w_grant;
  logic             w_accept;
  logic             w_handshake;
  logic [WIDTH-1:0] w_y;

  // w_cand[k] is the k-th requester in priority order starting at r_ptr.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_op[gi]   = bus.req_op[2*gi +: 2];
      assign w_a[gi]    = bus.req_a[WIDTH*gi +: WIDTH];
      assign w_b[gi]    = bus.req_b[WIDTH*gi +: WIDTH];
      assign w_cand[gi] = IDW'((32'(r_ptr) + gi) % NREQ);
    end
  endgenerate

  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && bus.req_valid[w_cand[k]]) begin
        w_any   = 1'b1;
        w_grant = w_cand[k];
      end
    end
  end

  assign w_accept    = (r_state == S_IDLE) && w_any;
  assign w_handshake = (r_state == S_RESP) && bus.resp_ready;

  always_comb begin
    unique case (r_op)
      2'b00:   w_y = r_a & r_b;
      2'b01:   w_y = r_a | r_b;
      2'b10:   w_y = r_a ^ r_b;
      default: w_y = ~(r_a ^ r_b);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (bus.resp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // rst_n gate keeps req_ready low while reset is held with requests pending.
  always_comb begin
    bus.req_ready = '0;
    if (w_accept && rst_n) bus.req_ready[w_grant] = 1'b1;
    bus.resp_valid = (r_state == S_RESP);
    busy           = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_resp_id <= '0;
      r_resp_y  <= '0;
`ifdef GATE_ARB_PARITY_EN
      r_resp_parity <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_id <= w_grant;
        r_op <= w_op[w_grant];
        r_a  <= w_a[w_grant];
        r_b  <= w_b[w_grant];
      end
      if (r_state == S_EXEC) begin
        r_resp_id <= r_id;
        r_resp_y  <= w_y;
`ifdef GATE_ARB_PARITY_EN
        r_resp_parity <= ^w_y;
`endif
      end
      // Pointer moves past the served requester only once its result drains.
      if (w_handshake) begin
        r_ptr <= (r_resp_id == IDW'(NREQ-1)) ? '0 : r_resp_id + 1'b1;
      end
    end
  end

  assign bus.resp_id = r_resp_id;
  assign bus.resp_y  = r_resp_y;
`ifdef GATE_ARB_PARITY_EN
  assign bus.resp_parity = r_resp_parity;
`endif

endmodule
